tft_window_scheduler: RTL
=========================

# tft_window_scheduler

- Sequences the ILI9488 byte-level SPI driver to write one rectangular window of RGB888 pixels into display GRAM.
- Per window it issues, in order: column-address set (0x2A), page-address set (0x2B), memory write (0x2C), then streams pixels from an upstream source (camera or convolution engine) as three data bytes each.
- Sits between pixel producers and the driver, after panel initialisation is complete.

## Interface
- H_RES, 320, panel columns; valid x range 0..H_RES-1
- V_RES, 480, panel rows; valid y range 0..V_RES-1
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- win_valid  in  1  window request
- win_ready  out  1  high only in IDLE
- win_x0, win_x1  in  9  inclusive column bounds
- win_y0, win_y1  in  9  inclusive row bounds
- pix_valid  in  1  pixel available
- pix_data  in  24  {R[23:16], G[15:8], B[7:0]}
- pix_ready  out  1  high only in FETCH; transfer = pix_valid & pix_ready
- abort  in  1  level; stops the pixel phase (e.g. tied to VS)
- drv_load  out  1  byte load request to driver
- drv_dc  out  1  0 = command byte, 1 = data byte
- drv_data  out  8  byte to send
- drv_load_comp  in  1  driver accepted byte
- drv_write_comp  in  1  driver finished shifting byte
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse: window completed
- err  out  1  one-cycle pulse: window rejected
- aborted  out  1  one-cycle pulse: window aborted

## Operation
- States: IDLE, HDR_SEND, HDR_WAIT, FETCH, PIX_SEND, PIX_WAIT.
- **IDLE:** on win_valid, check x0<=x1<H_RES and y0<=y1<V_RES.
  - Valid: latch all four bounds, set hdr_idx=0, go to HDR_SEND.
  - Invalid: pulse err, stay in IDLE.
- **Header sequence** (hdr_idx 0..10), with dc=0 for commands and 1 for data:
  - 0: 0x2A cmd; 1..4: x0[15:8], x0[7:0], x1[15:8], x1[7:0]
  - 5: 0x2B cmd; 6..9: y0 hi, y0 lo, y1 hi, y1 lo
  - 10: 0x2C cmd
  - Bounds are zero-extended to 16 bits.
- **HDR_SEND:** drv_load=1 with the byte for hdr_idx. Hold until drv_load_comp, then go to HDR_WAIT.
- **HDR_WAIT:** on drv_write_comp:
  - hdr_idx==10: go to FETCH with col=x0, row=y0.
  - Otherwise: hdr_idx+1, back to HDR_SEND.
- **FETCH:** pix_ready=1. On transfer, latch pix_data, set byte_idx=0, go to PIX_SEND.
- **PIX_SEND:** drv_load=1, dc=1, data = R, G or B for byte_idx 0, 1, 2. On drv_load_comp go to PIX_WAIT.
- **PIX_WAIT:** on drv_write_comp:
  - byte_idx<2: byte_idx+1, go to PIX_SEND.
  - Else if col==x1 and row==y1: pulse done, go to IDLE.
  - Else: advance col (wrap to x0 and row+1 when col==x1), go to FETCH.
- **Abort:**
  - Sampled in FETCH, PIX_SEND and PIX_WAIT only.
  - In FETCH: go to IDLE and pulse aborted. A pixel offered in the same cycle is not consumed (pix_ready is forced low).
  - In PIX_SEND/PIX_WAIT: the in-flight byte completes (drv_write_comp), the remaining bytes of that pixel are dropped, then go to IDLE and pulse aborted.
  - If that completion is also the final byte of the window, done is pulsed and aborted is not.
  - Abort during the header phase is ignored.
- drv_load is never asserted outside HDR_SEND and PIX_SEND.
- drv_data and drv_dc are 0 when drv_load=0.

## Timing
- Reset values:
  - 0: state IDLE, drv_load, drv_dc, drv_data, pix_ready, busy, done, err, aborted.
  - 1: win_ready.
  - Async reset mid-transfer drops drv_load immediately; the driver is not waited on.
- Window accept to first drv_load: 1 cycle.
- drv_load_comp and drv_write_comp are only observed in their own SEND/WAIT state.
  - The driver guarantees drv_write_comp arrives at least 1 cycle after drv_load_comp.
  - A drv_write_comp seen in a SEND state is ignored.
- drv_write_comp of the last byte to done: done is high in the following cycle; win_ready is high in that same cycle.
- Minimum per pixel: 1 FETCH cycle plus 3 byte handshakes. No pixel is double-counted or skipped.
- Counters: col and row are 9 bits.
- Maximum window is 320x480 = 153600 pixels, i.e. 460800 data bytes plus 11 header bytes.

## Test plan
- Reset, then window (0,0)-(0,0), one pixel 0x123456:
  - Driver sees 2A/00/00/00/00, 2B/00/00/00/00, 2C (dc=0 on the three commands), then data 12,34,56.
  - Exactly one done pulse.
- Window (310,470)-(319,479) with 100 pixels: header bytes 01,36,01,3F and 01,D6,01,DF; 300 data bytes; done after the 300th drv_write_comp.
- Invalid windows: (5,0)-(4,0) and (0,0)-(320,0) each give one err pulse. No drv_load; win_ready stays 1.
- pix_valid withheld 20 cycles in FETCH: pix_ready stays 1 and drv_load stays 0; the pixel's first drv_load comes 1 cycle after the transfer.
- abort asserted during the G byte of pixel 3:
  - G completes, B is not sent, aborted pulses once, state returns to IDLE, no done.
  - A second abort asserted during the header is ignored.
- Driver delays drv_write_comp 50 cycles per byte, with a spurious write_comp in SEND: byte order is unchanged and the spurious pulse causes no skip.

Source files
------------

// File: rtl/tft_window_scheduler_if.sv
// tft_window_scheduler_if: window request, pixel stream and byte-driver handshakes
interface tft_window_scheduler_if;
  logic        i_win_valid;
  logic        o_win_ready;
  logic [8:0]  i_win_x0;
  logic [8:0]  i_win_x1;
  logic [8:0]  i_win_y0;
  logic [8:0]  i_win_y1;
  logic        i_pix_valid;
  logic [23:0] i_pix_data;
  logic        o_pix_ready;
  logic        i_abort;
  logic        o_drv_load;
  logic        o_drv_dc;
  logic [7:0]  o_drv_data;
  logic        i_drv_load_comp;
  logic        i_drv_write_comp;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_aborted;
  modport slave (
    input  i_win_valid, i_win_x0, i_win_x1, i_win_y0, i_win_y1,
    input  i_pix_valid, i_pix_data, i_abort, i_drv_load_comp, i_drv_write_comp,
    output o_win_ready, o_pix_ready, o_drv_load, o_drv_dc, o_drv_data,
    output o_busy, o_done, o_err, o_aborted
  );
  modport master (
    output i_win_valid, i_win_x0, i_win_x1, i_win_y0, i_win_y1,
    output i_pix_valid, i_pix_data, i_abort, i_drv_load_comp, i_drv_write_comp,
    input  o_win_ready, o_pix_ready, o_drv_load, o_drv_dc, o_drv_data,
    input  o_busy, o_done, o_err, o_aborted
  );
endinterface

// File: rtl/tft_window_scheduler.sv
// tft_window_scheduler: writes one RGB888 window to ILI9488 GRAM through the byte-level SPI driver
module tft_window_scheduler #(
  parameter int H_RES = 320,
  parameter int V_RES = 480
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  tft_window_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HDR_SEND, HDR_WAIT, FETCH, PIX_SEND, PIX_WAIT} state_t;
  state_t      r_state;
  logic [3:0]  r_hdr_idx;
  logic [1:0]  r_byte_idx;
  logic [8:0]  r_x0, r_x1, r_y0, r_y1, r_col, r_row;
  logic [15:0] r_pix_gb;
  logic        r_abort_pend;
  logic        r_drv_load, r_drv_dc, r_pix_ready, r_busy, r_done, r_err, r_aborted, r_win_ready;
  logic [7:0]  r_drv_data;
  logic [3:0]  w_nidx;
  logic [7:0]  w_hdr_byte;
  logic        w_hdr_dc;
  logic        w_win_ok;
  logic        w_last;
  assign w_nidx   = r_hdr_idx + 4'd1;
  assign w_hdr_dc = (w_nidx != 4'd5) && (w_nidx != 4'd10);
  assign w_win_ok = (bus.i_win_x0 <= bus.i_win_x1) && ({1'b0, bus.i_win_x1} < 10'(H_RES)) &&
                    (bus.i_win_y0 <= bus.i_win_y1) && ({1'b0, bus.i_win_y1} < 10'(V_RES));
  assign w_last   = (r_byte_idx == 2'd2) && (r_col == r_x1) && (r_row == r_y1);
  // Byte for the header slot about to be loaded; slot 0 (0x2A) is issued at accept
  always_comb
    case (w_nidx)
      4'd1:    w_hdr_byte = {7'd0, r_x0[8]};
      4'd2:    w_hdr_byte = r_x0[7:0];
      4'd3:    w_hdr_byte = {7'd0, r_x1[8]};
      4'd4:    w_hdr_byte = r_x1[7:0];
      4'd5:    w_hdr_byte = 8'h2B;
      4'd6:    w_hdr_byte = {7'd0, r_y0[8]};
      4'd7:    w_hdr_byte = r_y0[7:0];
      4'd8:    w_hdr_byte = {7'd0, r_y1[8]};
      4'd9:    w_hdr_byte = r_y1[7:0];
      default: w_hdr_byte = 8'h2C;
    endcase
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_hdr_idx    <= 4'd0;
      r_byte_idx   <= 2'd0;
      r_x0         <= 9'd0;
      r_x1         <= 9'd0;
      r_y0         <= 9'd0;
      r_y1         <= 9'd0;
      r_col        <= 9'd0;
      r_row        <= 9'd0;
      r_pix_gb     <= 16'd0;
      r_abort_pend <= 1'b0;
      r_drv_load   <= 1'b0;
      r_drv_dc     <= 1'b0;
      r_drv_data   <= 8'd0;
      r_pix_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_aborted    <= 1'b0;
      r_win_ready  <= 1'b1;
    end else begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        IDLE:
          if (bus.i_win_valid) begin
            if (w_win_ok) begin
              r_x0         <= bus.i_win_x0;
              r_x1         <= bus.i_win_x1;
              r_y0         <= bus.i_win_y0;
              r_y1         <= bus.i_win_y1;
              r_hdr_idx    <= 4'd0;
              r_abort_pend <= 1'b0;
              r_state      <= HDR_SEND;
              r_drv_load   <= 1'b1;
              r_drv_dc     <= 1'b0;
              r_drv_data   <= 8'h2A;
              r_win_ready  <= 1'b0;
              r_busy       <= 1'b1;
            end else
              r_err <= 1'b1;
          end
        HDR_SEND:
          if (bus.i_drv_load_comp) begin
            r_state    <= HDR_WAIT;
            r_drv_load <= 1'b0;
            r_drv_dc   <= 1'b0;
            r_drv_data <= 8'd0;
          end
        HDR_WAIT:
          if (bus.i_drv_write_comp) begin
            if (r_hdr_idx == 4'd10) begin
              r_state     <= FETCH;
              r_col       <= r_x0;
              r_row       <= r_y0;
              r_pix_ready <= 1'b1;
            end else begin
              r_hdr_idx  <= w_nidx;
              r_state    <= HDR_SEND;
              r_drv_load <= 1'b1;
              r_drv_dc   <= w_hdr_dc;
              r_drv_data <= w_hdr_byte;
            end
          end
        FETCH:
          if (bus.i_abort) begin
            r_state     <= IDLE;
            r_pix_ready <= 1'b0;
            r_aborted   <= 1'b1;
            r_busy      <= 1'b0;
            r_win_ready <= 1'b1;
          end else if (bus.i_pix_valid) begin
            r_pix_gb    <= bus.i_pix_data[15:0];
            r_byte_idx  <= 2'd0;
            r_state     <= PIX_SEND;
            r_pix_ready <= 1'b0;
            r_drv_load  <= 1'b1;
            r_drv_dc    <= 1'b1;
            r_drv_data  <= bus.i_pix_data[23:16];
          end
        PIX_SEND: begin
          if (bus.i_abort)
            r_abort_pend <= 1'b1;
          if (bus.i_drv_load_comp) begin
            r_state    <= PIX_WAIT;
            r_drv_load <= 1'b0;
            r_drv_dc   <= 1'b0;
            r_drv_data <= 8'd0;
          end
        end
        PIX_WAIT:
          if (bus.i_drv_write_comp) begin
            // Completing the final byte wins over a pending abort
            if (w_last) begin
              r_state     <= IDLE;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_win_ready <= 1'b1;
            end else if (r_abort_pend || bus.i_abort) begin
              r_state     <= IDLE;
              r_aborted   <= 1'b1;
              r_busy      <= 1'b0;
              r_win_ready <= 1'b1;
            end else if (r_byte_idx != 2'd2) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_state    <= PIX_SEND;
              r_drv_load <= 1'b1;
              r_drv_dc   <= 1'b1;
              r_drv_data <= (r_byte_idx == 2'd0) ? r_pix_gb[15:8] : r_pix_gb[7:0];
            end else begin
              r_col       <= (r_col == r_x1) ? r_x0 : r_col + 9'd1;
              r_row       <= (r_col == r_x1) ? r_row + 9'd1 : r_row;
              r_state     <= FETCH;
              r_pix_ready <= 1'b1;
            end
          end else if (bus.i_abort)
            r_abort_pend <= 1'b1;
        default: begin
          r_state     <= IDLE;
          r_drv_load  <= 1'b0;
          r_drv_dc    <= 1'b0;
          r_drv_data  <= 8'd0;
          r_pix_ready <= 1'b0;
          r_busy      <= 1'b0;
          r_win_ready <= 1'b1;
        end
      endcase
    end
  assign bus.o_win_ready = r_win_ready;
  assign bus.o_pix_ready = r_pix_ready & ~bus.i_abort;
  assign bus.o_drv_load  = r_drv_load;
  assign bus.o_drv_dc    = r_drv_dc;
  assign bus.o_drv_data  = r_drv_data;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_err       = r_err;
  assign bus.o_aborted   = r_aborted;
endmodule
